// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzifier datapath.
package fuzzy_pkg;

   // One trapezoid membership function: breakpoints a <= b <= c <= d, signed Q7.0.
   typedef struct packed {
      logic signed [7:0] a;
      logic signed [7:0] b;
      logic signed [7:0] c;
      logic signed [7:0] d;
   } mf_params_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      OUT  = 2'd2
   } fsm_state_t;

   localparam logic [15:0] MU_ONE  = 16'h7FFF;
   localparam logic [15:0] MU_ZERO = 16'h0000;

   // A bank entry is only meaningful when its breakpoints are non-decreasing.
   function automatic logic params_ordered(input mf_params_t p);
      return ($signed(p.a) <= $signed(p.b)) &&
             ($signed(p.b) <= $signed(p.c)) &&
             ($signed(p.c) <= $signed(p.d));
   endfunction

endpackage

// File: rtl/fuzzifier_seq_if.sv
// Config, start and mu-stream handshake bundle for fuzzifier_seq.
// FUZZ_ARGMAX_EN adds the running-argmax result signals.
interface fuzzifier_seq_if #(
   parameter int N_MF = 4
);
   localparam int IDX_W = $clog2(N_MF);

   logic                    cfg_we;
   logic [IDX_W-1:0]        cfg_idx;
   logic signed [7:0]       cfg_a;
   logic signed [7:0]       cfg_b;
   logic signed [7:0]       cfg_c;
   logic signed [7:0]       cfg_d;
   logic                    cfg_ready;
   logic                    cfg_err;
   logic                    start_valid;
   logic                    start_ready;
   logic signed [7:0]       x_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [15:0]             mu_out;
   logic [IDX_W-1:0]        mu_idx;
   logic                    mu_last;
   logic                    busy;
`ifdef FUZZ_ARGMAX_EN
   logic [IDX_W-1:0]        max_idx;
   logic [15:0]             max_mu;

   modport master (
      output cfg_we, cfg_idx, cfg_a, cfg_b, cfg_c, cfg_d, start_valid, x_in, out_ready,
      input  cfg_ready, cfg_err, start_ready, out_valid, mu_out, mu_idx, mu_last, busy,
             max_idx, max_mu
   );
   modport slave (
      input  cfg_we, cfg_idx, cfg_a, cfg_b, cfg_c, cfg_d, start_valid, x_in, out_ready,
      output cfg_ready, cfg_err, start_ready, out_valid, mu_out, mu_idx, mu_last, busy,
             max_idx, max_mu
   );
`else
   modport master (
      output cfg_we, cfg_idx, cfg_a, cfg_b, cfg_c, cfg_d, start_valid, x_in, out_ready,
      input  cfg_ready, cfg_err, start_ready, out_valid, mu_out, mu_idx, mu_last, busy
   );
   modport slave (
      input  cfg_we, cfg_idx, cfg_a, cfg_b, cfg_c, cfg_d, start_valid, x_in, out_ready,
      output cfg_ready, cfg_err, start_ready, out_valid, mu_out, mu_idx, mu_last, busy
   );
`endif

endinterface

// File: rtl/fuzzifier_seq_trap.sv
// Combinational trapezoid membership evaluator: Q7.0 x -> Q1.15 mu.
module fuzzifier_seq_trap
   import fuzzy_pkg::*;
(
   input  logic signed [7:0] x,
   input  mf_params_t        p,
   output logic [15:0]       mu
);

   logic signed [8:0] x_e, a_e, b_e, c_e, d_e;
   logic [8:0]        rise_n, rise_d, fall_n, fall_d;

   assign x_e = {x[7], x};
   assign a_e = {p.a[7], p.a};
   assign b_e = {p.b[7], p.b};
   assign c_e = {p.c[7], p.c};
   assign d_e = {p.d[7], p.d};

   // Differences are only consumed where they are positive; divisors are forced
   // non-zero so the unselected quotient never divides by zero.
   assign rise_n = 9'(x_e - a_e);
   assign fall_n = 9'(d_e - x_e);
   assign rise_d = (b_e == a_e) ? 9'd1 : 9'(b_e - a_e);
   assign fall_d = (d_e == c_e) ? 9'd1 : 9'(d_e - c_e);

   // Region select: outside support, plateau, rising edge, falling edge.
   always_comb begin
      mu = MU_ZERO;
      if ((x_e <= a_e) || (x_e >= d_e))
         mu = MU_ZERO;
      else if ((x_e >= b_e) && (x_e <= c_e))
         mu = MU_ONE;
      else if (x_e < b_e)
         mu = 16'({rise_n, 15'b0} / {15'b0, rise_d});
      else
         mu = 16'({fall_n, 15'b0} / {15'b0, fall_d});
   end

endmodule

// File: rtl/fuzzifier_seq.sv
// Sequences one shared trapezoid evaluator across an N_MF parameter bank and
// streams one mu beat per MF. FUZZ_ARGMAX_EN enables running argmax outputs.
module fuzzifier_seq
   import fuzzy_pkg::*;
#(
   parameter int N_MF = 4
) (
   input logic             clk,
   input logic             rst,
   fuzzifier_seq_if.slave  bus
);

   localparam int IDX_W = $clog2(N_MF);

   fsm_state_t          state_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic signed [7:0]   x_reg;
   logic [15:0]         mu_reg;
   logic [IDX_W-1:0]    mu_idx_reg;
   logic                last_reg;
   logic                valid_reg;
   logic                err_reg;
   mf_params_t          bank [N_MF];
   mf_params_t          cfg_p;
   logic                cfg_commit;
   logic [15:0]         mu_calc;

   assign cfg_p      = '{a: bus.cfg_a, b: bus.cfg_b, c: bus.cfg_c, d: bus.cfg_d};
   assign cfg_commit = bus.cfg_we && (state_reg == IDLE) && params_ordered(cfg_p) &&
                       (32'(bus.cfg_idx) < N_MF);

   genvar gi;
   generate
      for (gi = 0; gi < N_MF; gi++) begin : g_bank
         mf_params_t entry_reg;
         // Parameter bank entry: cleared on reset, written only by a validated commit.
         always_ff @(posedge clk) begin
            if (rst)
               entry_reg <= '0;
            else if (cfg_commit && (32'(bus.cfg_idx) == gi))
               entry_reg <= cfg_p;
         end
         assign bank[gi] = entry_reg;
      end
   endgenerate

   fuzzifier_seq_trap u_trap (
      .x  (x_reg),
      .p  (bank[idx_reg]),
      .mu (mu_calc)
   );

`ifdef FUZZ_ARGMAX_EN
   logic [IDX_W-1:0] max_idx_reg;
   logic [15:0]      max_mu_reg;
`endif

   // Sweep FSM with registered beat fields and the cfg reject pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         idx_reg    <= '0;
         x_reg      <= '0;
         mu_reg     <= MU_ZERO;
         mu_idx_reg <= '0;
         last_reg   <= 1'b0;
         valid_reg  <= 1'b0;
         err_reg    <= 1'b0;
`ifdef FUZZ_ARGMAX_EN
         max_idx_reg <= '0;
         max_mu_reg  <= MU_ZERO;
`endif
      end else begin
         err_reg <= bus.cfg_we && !cfg_commit;
         case (state_reg)
            IDLE: begin
               if (bus.start_valid) begin
                  x_reg     <= bus.x_in;
                  idx_reg   <= '0;
                  state_reg <= EVAL;
`ifdef FUZZ_ARGMAX_EN
                  max_idx_reg <= '0;
                  max_mu_reg  <= MU_ZERO;
`endif
               end
            end
            EVAL: begin
               mu_reg     <= mu_calc;
               mu_idx_reg <= idx_reg;
               last_reg   <= (32'(idx_reg) == N_MF - 1);
               valid_reg  <= 1'b1;
               state_reg  <= OUT;
`ifdef FUZZ_ARGMAX_EN
               if (mu_calc > max_mu_reg) begin
                  max_mu_reg  <= mu_calc;
                  max_idx_reg <= idx_reg;
               end
`endif
            end
            OUT: begin
               if (bus.out_ready) begin
                  valid_reg <= 1'b0;
                  if (last_reg) begin
                     state_reg <= IDLE;
                  end else begin
                     idx_reg   <= idx_reg + 1'b1;
                     state_reg <= EVAL;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cfg_ready   = (state_reg == IDLE);
   assign bus.start_ready = (state_reg == IDLE);
   assign bus.busy        = (state_reg != IDLE);
   assign bus.cfg_err     = err_reg;
   assign bus.out_valid   = valid_reg;
   assign bus.mu_out      = mu_reg;
   assign bus.mu_idx      = mu_idx_reg;
   assign bus.mu_last     = last_reg;
`ifdef FUZZ_ARGMAX_EN
   assign bus.max_idx     = max_idx_reg;
   assign bus.max_mu      = max_mu_reg;
`endif

endmodule

// File: tb/tb_fuzzifier_seq.sv
// Directed self-checking bench for fuzzifier_seq (N_MF=4).
module tb_fuzzifier_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fuzzifier_seq_if #(.N_MF(4)) bus ();

   fuzzifier_seq #(.N_MF(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int idx, input int a, input int b, input int c, input int d);
      bus.cfg_we  = 1'b1;
      bus.cfg_idx = 2'(idx);
      bus.cfg_a   = 8'(a);
      bus.cfg_b   = 8'(b);
      bus.cfg_c   = 8'(c);
      bus.cfg_d   = 8'(d);
   endtask

   task automatic cfg_write(input int idx, input int a, input int b, input int c, input int d,
                            input logic exp_err);
      set_cfg(idx, a, b, c, d);
      tick();
      bus.cfg_we = 1'b0;
      check($sformatf("cfg_err idx%0d", idx), 32'(bus.cfg_err), 32'(exp_err));
   endtask

   // mode 0: plain start; 1: cfg write of MF3 on the start edge; 2: cfg write mid-sweep
   task automatic start_x(input int x, input int mode);
      bus.x_in        = 8'(x);
      bus.start_valid = 1'b1;
      if (mode == 1) set_cfg(3, -10, 0, 10, 20);
      tick();
      bus.start_valid = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.x_in        = 8'(-1);
      check("latency T out_valid", 32'(bus.out_valid), 32'd0);
      check("latency T busy", 32'(bus.busy), 32'd1);
      if (mode == 1) check("cfg+start cfg_err", 32'(bus.cfg_err), 32'd0);
      if (mode == 2) set_cfg(3, -10, 0, 10, 20);
      tick();
      bus.cfg_we = 1'b0;
      check("latency T+1 out_valid", 32'(bus.out_valid), 32'd1);
      if (mode == 2) begin
         check("busy cfg_err", 32'(bus.cfg_err), 32'd1);
         check("busy cfg_ready", 32'(bus.cfg_ready), 32'd0);
      end
   endtask

   task automatic wait_valid();
      for (int n = 0; n < 20 && !bus.out_valid; n++) tick();
   endtask

   task automatic drain(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3, input int stall_beat);
      logic [15:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++) begin
         wait_valid();
         check($sformatf("%s b%0d valid", tag, k), 32'(bus.out_valid), 32'd1);
         check($sformatf("%s b%0d mu", tag, k), 32'(bus.mu_out), 32'(e[k]));
         check($sformatf("%s b%0d idx", tag, k), 32'(bus.mu_idx), 32'(k));
         check($sformatf("%s b%0d last", tag, k), 32'(bus.mu_last), 32'(k == 3));
         if (k == stall_beat) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               check($sformatf("%s stall%0d valid", tag, s), 32'(bus.out_valid), 32'd1);
               check($sformatf("%s stall%0d mu", tag, s), 32'(bus.mu_out), 32'(e[k]));
               check($sformatf("%s stall%0d idx", tag, s), 32'(bus.mu_idx), 32'(k));
               check($sformatf("%s stall%0d last", tag, s), 32'(bus.mu_last), 32'd0);
            end
            bus.out_ready = 1'b1;
         end
         tick();
      end
      check($sformatf("%s done busy", tag), 32'(bus.busy), 32'd0);
      check($sformatf("%s done valid", tag), 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_idx     = '0;
      bus.cfg_a       = '0;
      bus.cfg_b       = '0;
      bus.cfg_c       = '0;
      bus.cfg_d       = '0;
      bus.start_valid = 1'b0;
      bus.x_in        = '0;
      bus.out_ready   = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst cfg_ready", 32'(bus.cfg_ready), 32'd1);
      check("rst start_ready", 32'(bus.start_ready), 32'd1);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst cfg_err", 32'(bus.cfg_err), 32'd0);
      check("rst mu_out", 32'(bus.mu_out), 32'd0);
      rst = 1'b0;
      tick();

      // 1: default bank gives mu=0 everywhere
      start_x(5, 0);
      drain("t1", 16'h0, 16'h0, 16'h0, 16'h0, -1);

      // 2: rising edge of MF0 at x=-30
      cfg_write(0, -40, -20, 0, 20, 1'b0);
      cfg_write(1, 0, 20, 40, 60, 1'b0);
      start_x(-30, 0);
      drain("t2", 16'h4000, 16'h0, 16'h0, 16'h0, -1);

      // 3: plateau and x=c / x=d boundaries
      start_x(-10, 0);
      drain("t3a", 16'h7FFF, 16'h0, 16'h0, 16'h0, -1);
      start_x(20, 0);
      drain("t3b", 16'h0, 16'h7FFF, 16'h0, 16'h0, -1);

      // 4: backpressure on beat1
      start_x(20, 0);
      drain("t4", 16'h0, 16'h7FFF, 16'h0, 16'h0, 1);

      // 5: misordered write rejected, bank unchanged
      cfg_write(2, 10, 5, 20, 30, 1'b1);
      start_x(15, 0);
      drain("t5a", 16'h2000, 16'h6000, 16'h0, 16'h0, -1);
      // write while busy is dropped
      start_x(5, 2);
      drain("t5b", 16'h6000, 16'h2000, 16'h0, 16'h0, -1);
      // write and start on the same edge: sweep sees new MF3
      start_x(5, 1);
      drain("t5c", 16'h6000, 16'h2000, 16'h0, 16'h7FFF, -1);

      // 6: reset on beat2 aborts and clears the bank
      start_x(5, 0);
      for (int k = 0; k < 2; k++) begin
         wait_valid();
         tick();
      end
      wait_valid();
      check("t6 beat2 idx", 32'(bus.mu_idx), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6 out_valid", 32'(bus.out_valid), 32'd0);
      check("t6 busy", 32'(bus.busy), 32'd0);
      check("t6 start_ready", 32'(bus.start_ready), 32'd1);
      start_x(5, 0);
      drain("t6 cleared", 16'h0, 16'h0, 16'h0, 16'h0, -1);

`ifdef FUZZ_ARGMAX_EN
      // argmax: ties keep the lowest index
      cfg_write(0, -40, -20, 0, 20, 1'b0);
      cfg_write(1, -40, -30, -20, 0, 1'b0);
      cfg_write(2, -40, -30, -20, 0, 1'b0);
      cfg_write(3, 0, 20, 40, 60, 1'b0);
      start_x(-30, 0);
      drain("argmax", 16'h4000, 16'h7FFF, 16'h7FFF, 16'h0, -1);
      check("max_idx", 32'(bus.max_idx), 32'd1);
      check("max_mu", 32'(bus.max_mu), 32'h7FFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
